// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
// Walks the sprite table once per scanline, tests each slot for vertical
// visibility against the latched line_y and hands every visible sprite to the
// sprite line counter as one job (sprite_on held until count_finished).
// Up to MAX_PER_LINE jobs are issued per line; extra visible sprites set the
// sticky overflow flag. A job that never completes is retired after
// JOB_TIMEOUT cycles.

module sprite_line_scheduler #(
    parameter  int N_SLOTS      = 32,
    parameter  int SPRITE_H     = 20,
    parameter  int MAX_PER_LINE = 8,
    parameter  int JOB_TIMEOUT  = 64,
    localparam int SLOT_W       = $clog2(N_SLOTS)
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              line_start,
    input  logic [9:0]        line_y,
    output logic [SLOT_W-1:0] slot_addr,
    input  logic [9:0]        slot_y,
    input  logic              slot_active,
    input  logic              count_finished,
    output logic              sprite_on,
    output logic [SLOT_W-1:0] sprite_slot,
    output logic [4:0]        sprite_row,
    output logic              line_done,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int JOBS_W  = $clog2(MAX_PER_LINE + 1);
    localparam int TIMER_W = $clog2(JOB_TIMEOUT + 1);

    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(N_SLOTS - 1);
    localparam logic [JOBS_W-1:0]  MAX_JOBS   = JOBS_W'(MAX_PER_LINE);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(JOB_TIMEOUT - 1);
    localparam logic [9:0]         HEIGHT     = 10'(SPRITE_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_START,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_q,       state_d;
    logic [SLOT_W-1:0]   slot_q,        slot_d;
    logic [JOBS_W-1:0]   jobs_q,        jobs_d;
    logic [TIMER_W-1:0]  timer_q,       timer_d;
    logic [9:0]          line_y_q,      line_y_d;
    logic                sprite_on_q,   sprite_on_d;
    logic [SLOT_W-1:0]   sprite_slot_q, sprite_slot_d;
    logic [4:0]          sprite_row_q,  sprite_row_d;
    logic                line_done_q,   line_done_d;
    logic                overflow_q,    overflow_d;
    logic                timeout_err_q, timeout_err_d;

    // Row offset of the slot under test. A slot below line_y wraps to a large
    // value, so the explicit line_y >= slot_y term keeps the window non-modular.
    logic [9:0] diff;
    logic       visible;

    assign diff    = line_y_q - slot_y;
    assign visible = slot_active && (line_y_q >= slot_y) && (diff < HEIGHT);

    // Next-state and next-output logic for the per-line walk.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d       = state_q;
        slot_d        = slot_q;
        jobs_d        = jobs_q;
        timer_d       = timer_q;
        line_y_d      = line_y_q;
        sprite_on_d   = sprite_on_q;
        sprite_slot_d = sprite_slot_q;
        sprite_row_d  = sprite_row_q;
        line_done_d   = 1'b0;
        overflow_d    = overflow_q;
        timeout_err_d = timeout_err_q;

        if (line_start && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            // A new line arrived before the walk finished: abandon it quietly.
            state_d     = S_IDLE;
            sprite_on_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (line_start) begin
                        line_y_d      = line_y;
                        slot_d        = '0;
                        jobs_d        = '0;
                        overflow_d    = 1'b0;
                        timeout_err_d = 1'b0;
                        state_d       = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_FETCH: begin
                    state_d = S_CHECK;
                end

                S_CHECK: begin
                    if (visible && (jobs_q < MAX_JOBS)) begin
                        sprite_slot_d = slot_q;
                        sprite_row_d  = diff[4:0];
                        sprite_on_d   = 1'b1;
                        timer_d       = '0;
                        state_d       = S_START;
                    end else if (visible) begin
                        overflow_d = 1'b1;
                        state_d    = S_NEXT;
                    end else begin
                        state_d = S_NEXT;
                    end
                end

                S_START: begin
                    if (!count_finished) begin
                        // Counter engaged; the timeout window restarts here.
                        timer_d = '0;
                        state_d = S_RUN;
                    end else if (timer_q == TIMER_LAST) begin
                        sprite_on_d = 1'b0;
                        state_d     = S_NEXT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                S_RUN: begin
                    if (count_finished) begin
                        sprite_on_d = 1'b0;
                        jobs_d      = jobs_q + 1'b1;
                        state_d     = S_NEXT;
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_err_d = 1'b1;
                        sprite_on_d   = 1'b0;
                        jobs_d        = jobs_q + 1'b1;
                        state_d       = S_NEXT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                S_NEXT: begin
                    if (slot_q == LAST_SLOT) begin
                        line_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end

                default: begin
                    sprite_on_d = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; outputs are driven straight from flops.
    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            slot_q        <= '0;
            jobs_q        <= '0;
            timer_q       <= '0;
            line_y_q      <= '0;
            sprite_on_q   <= 1'b0;
            sprite_slot_q <= '0;
            sprite_row_q  <= '0;
            line_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q       <= state_d;
            slot_q        <= slot_d;
            jobs_q        <= jobs_d;
            timer_q       <= timer_d;
            line_y_q      <= line_y_d;
            sprite_on_q   <= sprite_on_d;
            sprite_slot_q <= sprite_slot_d;
            sprite_row_q  <= sprite_row_d;
            line_done_q   <= line_done_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // The table address is the walk position itself, so the read issued in
    // FETCH returns data in CHECK.
    assign slot_addr   = slot_q;
    assign sprite_on   = sprite_on_q;
    assign sprite_slot = sprite_slot_q;
    assign sprite_row  = sprite_row_q;
    assign line_done   = line_done_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler
// Directed bench for sprite_line_scheduler: a registered sprite table model,
// a behavioural sprite line counter (normal / stuck-finished / stuck-busy)
// and negedge monitors that log every job and line_done pulse.

module tb_sprite_line_scheduler;

    localparam int N_SLOTS = 32;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       line_start;
    logic [9:0] line_y;
    logic [4:0] slot_addr;
    logic [9:0] slot_y;
    logic       slot_active;
    logic       count_finished;
    logic       sprite_on;
    logic [4:0] sprite_slot;
    logic [4:0] sprite_row;
    logic       line_done;
    logic       overflow;
    logic       timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    sprite_line_scheduler dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .line_start     (line_start),
        .line_y         (line_y),
        .slot_addr      (slot_addr),
        .slot_y         (slot_y),
        .slot_active    (slot_active),
        .count_finished (count_finished),
        .sprite_on      (sprite_on),
        .sprite_slot    (sprite_slot),
        .sprite_row     (sprite_row),
        .line_done      (line_done),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Sprite table with one cycle of read latency.
    logic [9:0] mem_y   [N_SLOTS];
    logic       mem_act [N_SLOTS];

    always @(posedge clk_pixel) begin
        slot_y      <= mem_y[slot_addr];
        slot_active <= mem_act[slot_addr];
    end

    // Sprite line counter: mode 0 engages for busy_len cycles per job,
    // mode 1 is stuck finished, mode 2 is stuck busy.
    int cf_mode  = 0;
    int busy_len = 20;
    int busy_cnt;
    bit job_seen;

    always @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            count_finished <= 1'b1;
            busy_cnt       <= 0;
            job_seen       <= 1'b0;
        end else if (cf_mode == 1) begin
            count_finished <= 1'b1;
            busy_cnt       <= 0;
            job_seen       <= 1'b0;
        end else if (cf_mode == 2) begin
            count_finished <= 1'b0;
            busy_cnt       <= 0;
            job_seen       <= 1'b0;
        end else if (sprite_on && !job_seen) begin
            count_finished <= 1'b0;
            busy_cnt       <= busy_len;
            job_seen       <= 1'b1;
        end else if (!count_finished) begin
            if (busy_cnt <= 1) count_finished <= 1'b1;
            else               busy_cnt <= busy_cnt - 1;
        end else if (!sprite_on) begin
            job_seen <= 1'b0;
        end
    end

    // Job and line_done monitors.
    int         job_cnt      = 0;
    int         done_cnt     = 0;
    int         on_len       = 0;
    int         unstable_cnt = 0;
    bit         son_prev     = 1'b0;
    logic [4:0] log_slot [$];
    logic [4:0] log_row  [$];

    always @(negedge clk_pixel) begin
        if (sprite_on) begin
            if (!son_prev) begin
                log_slot.push_back(sprite_slot);
                log_row.push_back(sprite_row);
                job_cnt++;
                on_len = 0;
            end else if (sprite_slot != log_slot[job_cnt-1] ||
                         sprite_row  != log_row[job_cnt-1]) begin
                unstable_cnt++;
            end
            on_len++;
        end
        if (line_done) done_cnt++;
        son_prev = sprite_on;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk_pixel);
        #1;
    endtask

    task automatic clear_table();
        for (int i = 0; i < N_SLOTS; i++) begin
            mem_y[i]   = 10'd0;
            mem_act[i] = 1'b0;
        end
    endtask

    int jb;  // job_cnt at the start of the latest line

    // Pulse line_start, wait for line_done and confirm it pulsed exactly once.
    task automatic run_line(input logic [9:0] y, input string tag);
        int  d0;
        bit  got;
        d0         = done_cnt;
        jb         = job_cnt;
        line_y     = y;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            tick();
            if (done_cnt != d0) got = 1'b1;
        end
        check({tag, " line_done seen"}, 32'(got), 32'd1);
        tick();
        tick();
        check({tag, " line_done pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_job(input string tag);
        int j0;
        bit got;
        j0  = job_cnt;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            tick();
            if (job_cnt != j0) got = 1'b1;
        end
        check({tag, " job started"}, 32'(got), 32'd1);
    endtask

    initial begin
        int d0;
        int j0;

        clear_table();
        reset      = 1'b0;
        line_start = 1'b0;
        line_y     = 10'd0;

        // T1: reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            tick();
            line_start = ~line_start;
            line_y     = 10'(i * 37);
        end
        check("T1 slot_addr",   32'(slot_addr),   32'd0);
        check("T1 sprite_on",   32'(sprite_on),   32'd0);
        check("T1 sprite_slot", 32'(sprite_slot), 32'd0);
        check("T1 sprite_row",  32'(sprite_row),  32'd0);
        check("T1 line_done",   32'(line_done),   32'd0);
        check("T1 overflow",    32'(overflow),    32'd0);
        check("T1 timeout_err", 32'(timeout_err), 32'd0);
        line_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();

        // T2: single sprite at slot 3, plus an inactive decoy at slot 4.
        mem_y[3] = 10'd100; mem_act[3] = 1'b1;
        mem_y[4] = 10'd100; mem_act[4] = 1'b0;
        run_line(10'd105, "T2");
        check("T2 jobs",        32'(job_cnt - jb),  32'd1);
        check("T2 slot",        32'(log_slot[jb]),  32'd3);
        check("T2 row",         32'(log_row[jb]),   32'd5);
        check("T2 on cycles",   32'(on_len),        32'd22);
        check("T2 overflow",    32'(overflow),      32'd0);
        check("T2 timeout_err", 32'(timeout_err),   32'd0);
        check("T2 sprite_on",   32'(sprite_on),     32'd0);

        // T3: window edges and no modular wrap.
        clear_table();
        mem_y[10] = 10'd100;  mem_act[10] = 1'b1;
        mem_y[11] = 10'd1010; mem_act[11] = 1'b1;
        run_line(10'd99, "T3 y99");
        check("T3 y99 jobs",  32'(job_cnt - jb), 32'd0);
        run_line(10'd100, "T3 y100");
        check("T3 y100 jobs", 32'(job_cnt - jb), 32'd1);
        check("T3 y100 row",  32'(log_row[jb]),  32'd0);
        run_line(10'd119, "T3 y119");
        check("T3 y119 jobs", 32'(job_cnt - jb), 32'd1);
        check("T3 y119 slot", 32'(log_slot[jb]), 32'd10);
        check("T3 y119 row",  32'(log_row[jb]),  32'd19);
        run_line(10'd120, "T3 y120");
        check("T3 y120 jobs", 32'(job_cnt - jb), 32'd0);
        run_line(10'd5, "T3 wrap");
        check("T3 wrap jobs", 32'(job_cnt - jb), 32'd0);
        run_line(10'd1013, "T3 top");
        check("T3 top jobs",  32'(job_cnt - jb), 32'd1);
        check("T3 top slot",  32'(log_slot[jb]), 32'd11);
        check("T3 top row",   32'(log_row[jb]),  32'd3);

        // T4: ten visible sprites, only eight scheduled.
        clear_table();
        for (int i = 0; i < 10; i++) begin
            mem_y[i]   = 10'd0;
            mem_act[i] = 1'b1;
        end
        run_line(10'd0, "T4");
        check("T4 jobs",       32'(job_cnt - jb),    32'd8);
        check("T4 first slot", 32'(log_slot[jb]),    32'd0);
        check("T4 last slot",  32'(log_slot[jb+7]),  32'd7);
        check("T4 overflow",   32'(overflow),        32'd1);
        run_line(10'd700, "T4 next");
        check("T4 next jobs",     32'(job_cnt - jb), 32'd0);
        check("T4 overflow clr",  32'(overflow),     32'd0);

        // T5: abort mid-job, then a clean walk from slot 0.
        clear_table();
        mem_y[2]  = 10'd50; mem_act[2]  = 1'b1;
        mem_y[20] = 10'd50; mem_act[20] = 1'b1;
        d0         = done_cnt;
        j0         = job_cnt;
        line_y     = 10'd55;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_job("T5");
        for (int i = 0; i < 8; i++) tick();
        check("T5 on before abort", 32'(sprite_on), 32'd1);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("T5 on after abort", 32'(sprite_on), 32'd0);
        for (int i = 0; i < 200; i++) tick();
        check("T5 no line_done", 32'(done_cnt - d0), 32'd0);
        check("T5 aborted jobs", 32'(job_cnt - j0),  32'd1);
        run_line(10'd55, "T5 rewalk");
        check("T5 rewalk jobs",  32'(job_cnt - jb),   32'd2);
        check("T5 rewalk slot0", 32'(log_slot[jb]),   32'd2);
        check("T5 rewalk slot1", 32'(log_slot[jb+1]), 32'd20);
        check("T5 rewalk row1",  32'(log_row[jb+1]),  32'd5);

        // T6: counter stuck finished, then stuck busy.
        clear_table();
        mem_y[5] = 10'd10; mem_act[5] = 1'b1;
        cf_mode = 1;
        tick();
        tick();
        run_line(10'd12, "T6 stuck1");
        check("T6 stuck1 jobs",    32'(job_cnt - jb), 32'd1);
        check("T6 stuck1 on",      32'(on_len),       32'd64);
        check("T6 stuck1 tmo_err", 32'(timeout_err),  32'd0);
        cf_mode = 2;
        tick();
        tick();
        run_line(10'd12, "T6 stuck0");
        check("T6 stuck0 slot",    32'(log_slot[jb]), 32'd5);
        check("T6 stuck0 on",      32'(on_len),       32'd65);
        check("T6 stuck0 tmo_err", 32'(timeout_err),  32'd1);
        cf_mode = 0;
        tick();
        tick();
        tick();
        run_line(10'd900, "T6 clear");
        check("T6 tmo_err clr", 32'(timeout_err), 32'd0);

        // Asynchronous reset in the middle of a job.
        clear_table();
        mem_y[0] = 10'd0; mem_act[0] = 1'b1;
        line_y     = 10'd0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_job("ARST");
        #2;
        reset = 1'b0;
        #1;
        check("ARST sprite_on", 32'(sprite_on), 32'd0);
        check("ARST slot_addr", 32'(slot_addr), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        check("slot/row stable during jobs", 32'(unstable_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
